// File: rtl/alu_scheduler_if.sv
// Bus bundle for alu_scheduler: two requester ports, the shared ALU port and
// the response port. The slave modport is the scheduler's view. The master
// modport is the view of the surrounding environment (requesters, ALU, consumer).
interface alu_scheduler_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [4:0]        req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [4:0]        req1_op;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [4:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_negative;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_negative;
  logic              rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_zero, alu_negative,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_negative, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_zero, alu_negative,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_negative, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one combinational ALU between two requesters.
// One operation is in flight at a time:
//   IDLE (grant and latch), then EXEC (ALU evaluates latched operands),
//   then RESP (hold the response until it is consumed).
// Optional build macro ALU_SCHED_FIXED_PRIO_EN makes requester 0 win every
// tie. Without it, ties alternate round-robin against the last grant.
module alu_scheduler #(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_scheduler_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Highest opcode the ALU implements; anything above is reported as an error
  localparam logic [4:0] OP_MAX = 5'd6;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [4:0]        alu_op_q, alu_op_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_negative_q, rsp_negative_d;
  logic              rsp_err_q, rsp_err_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
  logic              last_grant_q, last_grant_d;
`endif

  logic grant_any;
  logic grant_id;

  // Arbitration: pick the requester served when the scheduler is idle
  always_comb begin
    grant_any = (state_q == S_IDLE) && (bus.req0_valid || bus.req1_valid);
`ifdef ALU_SCHED_FIXED_PRIO_EN
    grant_id  = ~bus.req0_valid;
`else
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = ~bus.req0_valid;
    end
`endif
  end

  assign bus.req0_ready   = grant_any && !grant_id;
  assign bus.req1_ready   = grant_any &&  grant_id;

  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_op       = alu_op_q;

  assign bus.rsp_valid    = (state_q == S_RESP);
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_negative = rsp_negative_q;
  assign bus.rsp_err      = rsp_err_q;

  // Next-state logic: latch on accept, capture ALU outputs leaving EXEC, wait for consumer in RESP
  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_negative_d = rsp_negative_q;
    rsp_err_d      = rsp_err_q;
`ifndef ALU_SCHED_FIXED_PRIO_EN
    last_grant_d   = last_grant_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d  = S_EXEC;
          alu_a_d  = grant_id ? bus.req1_a  : bus.req0_a;
          alu_b_d  = grant_id ? bus.req1_b  : bus.req0_b;
          alu_op_d = grant_id ? bus.req1_op : bus.req0_op;
          rsp_id_d = grant_id;
`ifndef ALU_SCHED_FIXED_PRIO_EN
          last_grant_d = grant_id;
`endif
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
        if (alu_op_q > OP_MAX) begin
          // Unsupported opcode: ALU outputs are meaningless, report a clean error
          rsp_result_d   = '0;
          rsp_zero_d     = 1'b1;
          rsp_negative_d = 1'b0;
          rsp_err_d      = 1'b1;
        end else begin
          rsp_result_d   = bus.alu_result;
          rsp_zero_d     = bus.alu_zero;
          rsp_negative_d = bus.alu_negative;
          rsp_err_d      = 1'b0;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_negative_q <= 1'b0;
      rsp_err_q      <= 1'b0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      last_grant_q   <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_negative_q <= rsp_negative_d;
      rsp_err_q      <= rsp_err_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      last_grant_q   <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Testbench for alu_scheduler: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_alu_scheduler;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_scheduler_if #(.DATA_W(DATA_W)) bus ();

  alu_scheduler #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stand-in for the shared ALU; undefined opcodes produce junk
  always_comb begin
    case (bus.alu_op)
      5'd0:    bus.alu_result = bus.alu_a + bus.alu_b;
      5'd1:    bus.alu_result = bus.alu_a - bus.alu_b;
      5'd2:    bus.alu_result = bus.alu_a & bus.alu_b;
      5'd3:    bus.alu_result = bus.alu_a | bus.alu_b;
      5'd4:    bus.alu_result = ~bus.alu_a;
      5'd5:    bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      5'd6:    bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
      default: bus.alu_result = 32'hDEAD_BEEF;
    endcase
  end
  assign bus.alu_zero     = (bus.alu_result == '0);
  assign bus.alu_negative = bus.alu_result[DATA_W-1];

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        e;
  } rsp_t;

  rsp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state (transaction level)
  bit   inflight   = 1'b0;
  int   age        = 0;
  bit   last_grant = 1'b1;

  // Values observed during the most recent tick
  logic        s_r0, s_r1, s_rv, s_id, s_z, s_n, s_e;
  logic [31:0] s_res;
  bit          acc0, acc1, hs_rsp;

  function automatic rsp_t ref_rsp(logic id, logic [31:0] a, logic [31:0] b, logic [4:0] op);
    rsp_t r;
    r.id = id;
    r.e  = 1'b0;
    case (op)
      5'd0:    r.res = a + b;
      5'd1:    r.res = a - b;
      5'd2:    r.res = a & b;
      5'd3:    r.res = a | b;
      5'd4:    r.res = ~a;
      5'd5:    r.res = a << b[4:0];
      5'd6:    r.res = a >> b[4:0];
      default: begin r.res = 32'd0; r.e = 1'b1; end
    endcase
    r.z = (r.res == 32'd0);
    r.n = r.res[31];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs already applied; check at negedge, advance model, step past posedge
  task automatic tick();
    bit   any;
    logic g;
    bit   exp_rv;
    @(negedge clk);
    any = !inflight && (bus.req0_valid || bus.req1_valid);
`ifdef ALU_SCHED_FIXED_PRIO_EN
    g = bus.req0_valid ? 1'b0 : 1'b1;
`else
    if (bus.req0_valid && bus.req1_valid) g = ~last_grant;
    else                                  g = bus.req0_valid ? 1'b0 : 1'b1;
`endif
    exp_rv = inflight && (age >= 2);
    s_r0 = bus.req0_ready;  s_r1 = bus.req1_ready;  s_rv = bus.rsp_valid;
    s_id = bus.rsp_id;      s_res = bus.rsp_result; s_z = bus.rsp_zero;
    s_n  = bus.rsp_negative; s_e = bus.rsp_err;
    chk("req0_ready", s_r0, any && (g == 1'b0));
    chk("req1_ready", s_r1, any && (g == 1'b1));
    chk("rsp_valid", s_rv, exp_rv);
    if (exp_rv && s_rv === 1'b1) begin
      chk("rsp_id", s_id, exp_q[0].id);
      chk("rsp_result", s_res, exp_q[0].res);
      chk("rsp_zero", s_z, exp_q[0].z);
      chk("rsp_negative", s_n, exp_q[0].n);
      chk("rsp_err", s_e, exp_q[0].e);
    end
    acc0   = any && (g == 1'b0);
    acc1   = any && (g == 1'b1);
    hs_rsp = exp_rv && (bus.rsp_ready === 1'b1);
    if (hs_rsp) begin
      void'(exp_q.pop_front());
      inflight = 1'b0;
    end else if (inflight) begin
      age++;
    end
    if (any) begin
      if (g) exp_q.push_back(ref_rsp(1'b1, bus.req1_a, bus.req1_b, bus.req1_op));
      else   exp_q.push_back(ref_rsp(1'b0, bus.req0_a, bus.req0_b, bus.req0_op));
      inflight   = 1'b1;
      age        = 1;
      last_grant = g;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges; outputs must clear immediately
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_id", bus.rsp_id, 1'b0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_rsp_zero", bus.rsp_zero, 1'b0);
    chk("rst_rsp_negative", bus.rsp_negative, 1'b0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_op", bus.alu_op, 5'd0);
    inflight   = 1'b0;
    age        = 0;
    last_grant = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    for (int i = 0; i < 8 && inflight; i++) tick();
    chk("drain_idle", inflight, 1'b0);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] corners [4];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return $urandom();
  endfunction

  function automatic logic [4:0] rand_op();
    int k;
    k = $urandom_range(0, 8);
    if (k == 8) return 5'($urandom_range(7, 31));
    return 5'(k);
  endfunction

  logic ids [$];
  logic [31:0] held;

  initial begin
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp_ready  = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    tick();

    // Requester 0 alone: 5 + 3
    bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd3; bus.req0_op = 5'd0;
    tick();
    chk("add_accept", acc0, 1'b1);
    bus.req0_valid = 1'b0;
    tick();
    chk("add_exec_no_rsp", s_rv, 1'b0);
    tick();
    chk("add_rsp_valid", s_rv, 1'b1);
    chk("add_rsp_id", s_id, 1'b0);
    chk("add_result", s_res, 32'd8);
    chk("add_zero", s_z, 1'b0);
    chk("add_negative", s_n, 1'b0);
    tick();

    // Requester 1 alone: 3 - 3
    bus.req1_valid = 1'b1; bus.req1_a = 32'd3; bus.req1_b = 32'd3; bus.req1_op = 5'd1;
    tick();
    chk("sub_accept", acc1, 1'b1);
    bus.req1_valid = 1'b0;
    tick();
    tick();
    chk("sub_rsp_id", s_id, 1'b1);
    chk("sub_result", s_res, 32'd0);
    chk("sub_zero", s_z, 1'b1);
    tick();

    // Both requesters continuously valid: four back-to-back operations
    bus.req0_valid = 1'b1; bus.req0_a = rand_operand(); bus.req0_b = rand_operand(); bus.req0_op = rand_op();
    bus.req1_valid = 1'b1; bus.req1_a = rand_operand(); bus.req1_b = rand_operand(); bus.req1_op = rand_op();
    for (int c = 0; c < 12; c++) begin
      tick();
      if (hs_rsp) ids.push_back(s_id);
      if (acc0) begin bus.req0_a = rand_operand(); bus.req0_b = rand_operand(); bus.req0_op = rand_op(); end
      if (acc1) begin bus.req1_a = rand_operand(); bus.req1_b = rand_operand(); bus.req1_op = rand_op(); end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("rr_count", ids.size(), 32'd4);
    for (int k = 0; k < ids.size() && k < 4; k++) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
      chk("rr_id", ids[k], 1'b0);
`else
      chk("rr_id", ids[k], 1'((k % 2) != 0));
`endif
    end
    drain();

    // Unsupported opcode 9
    bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req0_op = 5'd9;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    tick();
    chk("bad_op_err", s_e, 1'b1);
    chk("bad_op_result", s_res, 32'd0);
    chk("bad_op_zero", s_z, 1'b1);
    chk("bad_op_negative", s_n, 1'b0);
    tick();

    // Consumer stalls five cycles in RESP while requester 1 waits
    bus.req0_valid = 1'b1; bus.req0_a = 32'hF0F0_1234; bus.req0_b = 32'h0FF0_FFFF; bus.req0_op = 5'd3;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h0000_00FF; bus.req1_b = 32'd4; bus.req1_op = 5'd5;
    tick();
    bus.rsp_ready = 1'b0;
    held = 32'hF0F0_1234 | 32'h0FF0_FFFF;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_req1_ready", s_r1, 1'b0);
      chk("stall_rsp_valid", s_rv, 1'b1);
      chk("stall_result", s_res, held);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("stall_handshake", hs_rsp, 1'b1);
    tick();
    chk("stall_single_rsp", s_rv, 1'b0);
    chk("stall_next_grant", acc1, 1'b1);
    drain();

    // Reset while an operation is in EXEC
    bus.req1_valid = 1'b1; bus.req1_a = 32'd7; bus.req1_b = 32'd9; bus.req1_op = 5'd0;
    tick();
    bus.req1_valid = 1'b0;
    do_reset();
    tick();
    tick();
    chk("rst_no_rsp", s_rv, 1'b0);
    bus.req0_valid = 1'b1; bus.req0_a = 32'd2; bus.req0_b = 32'd2; bus.req0_op = 5'd2;
    bus.req1_valid = 1'b1;
    tick();
    chk("rst_first_grant0", s_r0, 1'b1);
    chk("rst_first_grant1", s_r1, 1'b0);
    bus.req0_valid = 1'b0;
    drain();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      if (!bus.req0_valid && $urandom_range(0, 2) == 0) begin
        bus.req0_valid = 1'b1; bus.req0_a = rand_operand(); bus.req0_b = rand_operand(); bus.req0_op = rand_op();
      end
      if (!bus.req1_valid && $urandom_range(0, 2) == 0) begin
        bus.req1_valid = 1'b1; bus.req1_a = rand_operand(); bus.req1_b = rand_operand(); bus.req1_op = rand_op();
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc0) bus.req0_valid = 1'b0;
      if (acc1) bus.req1_valid = 1'b0;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
